// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin arbiter sharing one physical-memory line port
// between the instruction cache (i_*) and the data cache (d_*).
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   i_read/i_write/i_address/i_wdata -> i_rdata/i_resp   I-cache side
//   d_read/d_write/d_address/d_wdata -> d_rdata/d_resp   D-cache side
//   pmem_read/pmem_write/pmem_address/pmem_wdata         memory request
//   pmem_rdata/pmem_resp                                 memory response
//
// The winning request is latched at grant time, so the memory side sees
// stable signals regardless of what the requesters do afterwards. Every
// output comes straight from a flop.
module pmem_arbiter #(
    parameter int unsigned s_line = 256,
    parameter int unsigned s_addr = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [s_addr-1:0] i_address,
    input  logic [s_line-1:0] i_wdata,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_addr-1:0] d_address,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_addr-1:0] pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;      // 0 = I, 1 = D
    logic              last_q, last_d;        // port granted most recently
    logic              op_wr_q, op_wr_d;      // latched op: 1 = write
    logic [s_addr-1:0] addr_q, addr_d;
    logic [s_line-1:0] wdata_q, wdata_d;
    logic [s_line-1:0] line_buf_q, line_buf_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic              i_resp_q, i_resp_d;
    logic              d_resp_q, d_resp_d;

    logic              i_req, d_req;
    logic              grant_d;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;   // I-cache wins the first tie
            op_wr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            line_buf_q   <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            op_wr_q      <= op_wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            line_buf_q   <= line_buf_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
        end
    end

    // Next-state, grant and next-output logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        op_wr_d      = op_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        line_buf_d   = line_buf_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;
        // D wins when it alone requests, or on a tie when I went last
        grant_d      = d_req & (~i_req | ~last_q);

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_d      = grant_d;
                    last_d       = grant_d;
                    // A port asserting both read and write is a write
                    op_wr_d      = grant_d ? d_write : i_write;
                    addr_d       = grant_d ? d_address : i_address;
                    wdata_d      = grant_d ? d_wdata : i_wdata;
                    pmem_read_d  = ~op_wr_d;
                    pmem_write_d = op_wr_d;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (pmem_resp) begin
                    if (!op_wr_q) begin
                        line_buf_d = pmem_rdata;
                    end
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    i_resp_d     = ~owner_q;
                    d_resp_d     = owner_q;
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_rdata      = line_buf_q;
    assign d_rdata      = line_buf_q;
    assign i_resp       = i_resp_q;
    assign d_resp       = d_resp_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed-vector bench for pmem_arbiter. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_pmem_arbiter;

    localparam int unsigned S_LINE = 256;
    localparam int unsigned S_ADDR = 32;

    logic              clk;
    logic              rst;
    logic              i_read, i_write, d_read, d_write;
    logic [S_ADDR-1:0] i_address, d_address;
    logic [S_LINE-1:0] i_wdata, d_wdata;
    logic [S_LINE-1:0] i_rdata, d_rdata;
    logic              i_resp, d_resp;
    logic              pmem_read, pmem_write;
    logic [S_ADDR-1:0] pmem_address;
    logic [S_LINE-1:0] pmem_wdata;
    logic [S_LINE-1:0] pmem_rdata;
    logic              pmem_resp;

    int errors = 0;
    int checks = 0;

    pmem_arbiter #(.s_line(S_LINE), .s_addr(S_ADDR)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_write      (i_write),
        .i_address    (i_address),
        .i_wdata      (i_wdata),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [S_LINE-1:0] got,
                       input logic [S_LINE-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // All eight outputs at their idle/reset values
    task automatic chk_all_zero(input string tag);
        chk({tag, ".strobes"}, S_LINE'({pmem_read, pmem_write, i_resp, d_resp}), '0);
        chk({tag, ".addr"}, S_LINE'(pmem_address), '0);
        chk({tag, ".wdata"}, pmem_wdata, '0);
        chk({tag, ".i_rdata"}, i_rdata, '0);
        chk({tag, ".d_rdata"}, d_rdata, '0);
    endtask

    logic [S_LINE-1:0] pat;
    logic [S_LINE-1:0] last_read;
    logic [S_LINE-1:0] line_aa;
    logic [S_LINE-1:0] line_55;
    logic [S_LINE-1:0] dw_cont;
    logic [S_LINE-1:0] dw_1234;
    logic              exp_d;

    initial begin
        line_aa   = {32{8'hAA}};
        line_55   = {32{8'h55}};
        dw_cont   = {8{32'hFEED_F00D}};
        dw_1234   = {8{32'h1234_5678}};
        last_read = '0;

        rst        = 1'b0;
        i_read     = 1'b0; i_write = 1'b0;
        d_read     = 1'b0; d_write = 1'b0;
        i_address  = '0;   d_address = '0;
        i_wdata    = '0;   d_wdata   = '0;
        pmem_rdata = '0;   pmem_resp = 1'b0;

        // Reset held while requests and pmem_resp toggle
        tick();
        for (int c = 0; c < 4; c++) begin
            i_read    = c[0];
            d_write   = ~c[0];
            pmem_resp = c[0];
            tick();
            chk_all_zero("reset");
        end

        // Release with both ports requesting: I first, then alternate
        i_read    = 1'b1; i_address = 32'h0000_0100;
        d_write   = 1'b1; d_address = 32'h0000_0200; d_wdata = dw_cont;
        pmem_resp = 1'b0;
        rst       = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_d = t[0];
            tick();  // cycle 1: BUSY
            chk("cont.read", S_LINE'(pmem_read), S_LINE'(!exp_d));
            chk("cont.write", S_LINE'(pmem_write), S_LINE'(exp_d));
            chk("cont.addr", S_LINE'(pmem_address),
                exp_d ? S_LINE'(32'h0000_0200) : S_LINE'(32'h0000_0100));
            if (exp_d) chk("cont.wdata", pmem_wdata, dw_cont);
            pat        = {8{32'hC0DE_0000 + 32'(t)}};
            pmem_rdata = pat;
            pmem_resp  = 1'b1;
            tick();  // cycle 2: DONE
            pmem_resp = 1'b0;
            chk("cont.i_resp", S_LINE'(i_resp), S_LINE'(!exp_d));
            chk("cont.d_resp", S_LINE'(d_resp), S_LINE'(exp_d));
            chk("cont.done_strobes", S_LINE'({pmem_read, pmem_write}), '0);
            if (!exp_d) last_read = pat;
            chk("cont.line_buf", d_rdata, last_read);
            tick();  // cycle 3: IDLE
            chk("cont.idle", S_LINE'({pmem_read, pmem_write, i_resp, d_resp}), '0);
        end
        i_read  = 1'b0;
        d_write = 1'b0;

        // Single I read, 5-cycle memory latency, address wiggled mid-BUSY
        tick();
        i_read    = 1'b1;
        i_address = 32'h0000_1000;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("iread.read", S_LINE'(pmem_read), S_LINE'(1));
            chk("iread.addr", S_LINE'(pmem_address), S_LINE'(32'h0000_1000));
            chk("iread.resp", S_LINE'({i_resp, d_resp}), '0);
            if (c == 3) i_address = 32'hDEAD_0000;
        end
        pmem_rdata = line_aa;
        pmem_resp  = 1'b1;
        tick();  // cycle 6
        pmem_resp = 1'b0;
        chk("iread.i_resp", S_LINE'(i_resp), S_LINE'(1));
        chk("iread.d_resp", S_LINE'(d_resp), S_LINE'(0));
        chk("iread.i_rdata", i_rdata, line_aa);
        chk("iread.strobe_drop", S_LINE'(pmem_read), S_LINE'(0));
        i_read    = 1'b0;
        i_address = 32'h0000_1000;
        tick();  // cycle 7
        chk("iread.resp_once", S_LINE'(i_resp), S_LINE'(0));

        // D write, pmem_resp in cycle 3, line_buf must not change
        d_write   = 1'b1;
        d_address = 32'h8000_0040;
        d_wdata   = dw_1234;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("dwr.write", S_LINE'({pmem_read, pmem_write}), S_LINE'(2'b01));
            chk("dwr.addr", S_LINE'(pmem_address), S_LINE'(32'h8000_0040));
            chk("dwr.wdata", pmem_wdata, dw_1234);
        end
        pmem_rdata = line_55;
        pmem_resp  = 1'b1;
        tick();  // cycle 4
        pmem_resp = 1'b0;
        chk("dwr.d_resp", S_LINE'(d_resp), S_LINE'(1));
        chk("dwr.i_resp", S_LINE'(i_resp), S_LINE'(0));
        chk("dwr.line_buf", d_rdata, line_aa);
        d_write = 1'b0;
        tick();
        chk("dwr.resp_once", S_LINE'(d_resp), S_LINE'(0));

        // Reset during BUSY, then a stray pmem_resp
        i_read    = 1'b1;
        i_address = 32'h0000_3000;
        tick();
        chk("midrst.busy", S_LINE'(pmem_read), S_LINE'(1));
        rst = 1'b0;
        #1;
        chk_all_zero("midrst.async");
        i_read = 1'b0;
        tick();
        rst       = 1'b1;
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("midrst.stray", S_LINE'({pmem_read, pmem_write, i_resp, d_resp}), '0);
        tick();
        chk("midrst.stray2", S_LINE'({pmem_read, pmem_write, i_resp, d_resp}), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Two-port arbiter that shares the single 256-bit physical-memory line interface between the instruction L1 cache and the data L1 cache. It sits between both caches' `pmem_*` ports and main memory. It uses round-robin arbitration, latches the winning request so downstream signals stay stable, and buffers the returned line. Each requester receives exactly one single-cycle response per transaction.

## Interface

Parameters:
- `s_line`, 256: line width in bits.
- `s_addr`, 32: address width in bits.

Ports (`i_` = I-cache side, `d_` = D-cache side, `pmem_` = memory side):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `i_read`  in  1  I-cache line read request.
- `i_write`  in  1  I-cache line write request.
- `i_address`  in  s_addr  I-cache line address.
- `i_wdata`  in  s_line  I-cache write line.
- `i_rdata`  out  s_line  line returned to the I-cache.
- `i_resp`  out  1  I-cache transaction complete.
- `d_read`, `d_write`, `d_address`, `d_wdata`, `d_rdata`, `d_resp`: identical set for the D-cache.
- `pmem_read`  out  1  memory read strobe.
- `pmem_write`  out  1  memory write strobe.
- `pmem_address`  out  s_addr  memory address.
- `pmem_wdata`  out  s_line  memory write line.
- `pmem_rdata`  in  s_line  memory read line.
- `pmem_resp`  in  1  memory transaction complete.

## Operation

- States:
  - IDLE: no transaction.
  - BUSY: downstream transaction in flight.
  - DONE: response presented to the winner.
- Registers:
  - `owner`: 0 = I, 1 = D.
  - `last`: port granted most recently.
  - Latched `op`, address and wdata of the winning request.
  - `line_buf` (s_line).
- A port is requesting when its read or write is 1. If a port asserts both, it is treated as a write.
- IDLE:
  - One port requesting: grant it.
  - Both requesting: grant the port that is not `last`.
  - On grant: latch op, address and wdata; set `owner` and `last`; go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - Drive `pmem_read` or `pmem_write` from the latched op, and `pmem_address`/`pmem_wdata` from the latched values.
  - Changes on requester inputs are ignored.
  - On `pmem_resp`: capture `pmem_rdata` into `line_buf` if op is read; go to DONE.
- DONE:
  - Assert the owner's `*_resp` for exactly one cycle; the owner's `*_rdata` equals `line_buf`.
  - Next state is always IDLE.
- Each requester must hold its request and inputs stable until its resp, and drop the request the cycle after resp. The arbiter does not check this.
- `i_rdata` and `d_rdata` are both driven from `line_buf` at all times. Only `*_resp` qualifies them.
- Write transactions leave `line_buf` unchanged.
- A `pmem_resp` seen outside BUSY is ignored.
- Reset (asserted at any time, including mid-transaction):
  - Immediately forces IDLE, `owner`=0, `last`=1 (so the I-cache wins the first tie), `line_buf`=0.
  - Clears the latched op, address and wdata.
  - An in-flight memory transaction is abandoned; a `pmem_resp` that follows reset deassertion while in IDLE is ignored.

## Timing

- All outputs are decoded from registered state only; no requester input combinationally reaches any output.
- Reset values: `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `i_resp`=0, `d_resp`=0, `i_rdata`=0, `d_rdata`=0.
- Transaction timeline:
  - Request sampled in IDLE at cycle 0.
  - `pmem_read`/`pmem_write` high from cycle 1.
  - `pmem_resp` at cycle k (k ≥ 1): strobe drops at cycle k+1.
  - `*_resp` high in cycle k+1 only.
  - IDLE at cycle k+2, when a new grant can be sampled.
- Minimum request-to-resp latency is 2 cycles (`pmem_resp` in cycle 1). Back-to-back transactions are separated by one IDLE cycle.
- Exactly one of `pmem_read`/`pmem_write` is high in BUSY; both are 0 in IDLE and DONE.
- Fairness: when both ports request continuously, grants alternate I, D, I, D. Neither port waits more than one foreign transaction.

## Test plan

- **Reset:** hold `rst`=0 with requests and `pmem_resp` toggling → all outputs 0; the first grant after release, with both ports requesting, goes to the I-cache.
- **Single I read:** `i_read`=1, `i_address`=0x0000_1000; memory returns 0xAA…AA after 5 cycles → `pmem_read` high cycles 1–5 with address 0x1000, `i_resp` high only in cycle 6 with `i_rdata`=0xAA…AA, `d_resp` stays 0.
- **D write:** `d_write`=1, `d_address`=0x8000_0040, `d_wdata`=0x1234…; `pmem_resp` in cycle 3 → `pmem_write`=1 with matching address and data in cycles 1–3, `d_resp` in cycle 4, `line_buf` unchanged.
- **Contention:** I read and D write held continuously for 4 transactions → grant order I, D, I, D; each transaction is preceded by one IDLE cycle; no `*_resp` goes to the wrong port.
- **Input instability:** change `i_address` to 0xDEAD_0000 mid-BUSY → `pmem_address` keeps the latched value.
- **Reset mid-transaction:** assert reset during BUSY → outputs return to 0 asynchronously; a later stray `pmem_resp` produces no `*_resp`.
